// File: rtl/ppm_frame_pingpong_buffer_if.sv
// ppm_frame_pingpong_buffer_if: user-side and shift-side signals of the ping-pong frame buffer
interface ppm_frame_pingpong_buffer_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 5
);
  logic              le;
  logic [LEN_W-1:0]  n;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              start_trans;
  logic              send_done;
  logic [DATA_W-1:0] data_out;
  logic              shift_strobe;
  logic              user_recv_done;
  logic              frame_done;
  logic              len_err;
  logic [1:0]        frames_pending;
  modport master (
    output le, n, din, din_valid, start_trans, send_done,
    input  din_ready, data_out, shift_strobe, user_recv_done, frame_done, len_err, frames_pending
  );
  modport slave (
    input  le, n, din, din_valid, start_trans, send_done,
    output din_ready, data_out, shift_strobe, user_recv_done, frame_done, len_err, frames_pending
  );
endinterface

// File: rtl/ppm_frame_pingpong_buffer.sv
// ppm_frame_pingpong_buffer: two-bank frame buffer feeding the PPM shift-two stage
module ppm_frame_pingpong_buffer #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int LEN_W   = 5,
  parameter bit REVERSE = 1'b1
) (
  input logic clk,
  input logic rst,
  ppm_frame_pingpong_buffer_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  typedef enum logic {W_IDLE, W_RECV} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_SEND} r_state_t;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic [DATA_W-1:0] mem [2*DEPTH];
  logic [LEN_W-1:0]  len [2];
  logic [1:0]        full, full_nxt;
  logic              wr_ptr, rd_ptr;
  logic [IDX_W-1:0]  wr_idx, rd_idx, wr_end, rd_end, rd_first, rd_nxt;
  logic n_ok, wr_start, wr_err, wr_acc, wr_last, rd_arm, rd_go, rd_step, rd_last;
  always_comb begin
    n_ok     = bus.n != '0 && bus.n <= LEN_W'(DEPTH);
    wr_start = w_state == W_IDLE && bus.le && !full[wr_ptr] && n_ok;
    wr_err   = w_state == W_IDLE && bus.le && !full[wr_ptr] && !n_ok;
    wr_acc   = w_state == W_RECV && bus.din_valid && bus.din_ready;
    wr_end   = IDX_W'(len[wr_ptr] - LEN_W'(1));
    wr_last  = wr_acc && wr_idx == wr_end;
    rd_end   = IDX_W'(len[rd_ptr] - LEN_W'(1));
    rd_first = REVERSE ? rd_end : '0;
    rd_nxt   = REVERSE ? rd_idx - IDX_W'(1) : rd_idx + IDX_W'(1);
    rd_arm   = r_state == R_IDLE && full[rd_ptr];
    rd_go    = r_state == R_WAIT && bus.start_trans;
    rd_step  = r_state == R_SEND && bus.send_done;
    rd_last  = rd_step && rd_idx == (REVERSE ? '0 : rd_end);
    w_next   = wr_start ? W_RECV : wr_last ? W_IDLE : w_state;
    r_next   = rd_arm ? R_WAIT : rd_go ? R_SEND : rd_last ? R_IDLE : r_state;
    full_nxt = full;
    if (wr_last) full_nxt[wr_ptr] = 1'b1;
    if (rd_last) full_nxt[rd_ptr] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end
  // Frame storage and latched lengths survive reset; the full flags alone decide validity.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[{wr_ptr, wr_idx}] <= bus.din;
    if (wr_start) len[wr_ptr] <= bus.n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      full               <= '0;
      wr_ptr             <= 1'b0;
      rd_ptr             <= 1'b0;
      wr_idx             <= '0;
      rd_idx             <= '0;
      bus.din_ready      <= 1'b0;
      bus.data_out       <= '0;
      bus.shift_strobe   <= 1'b0;
      bus.user_recv_done <= 1'b0;
      bus.frame_done     <= 1'b0;
      bus.len_err        <= 1'b0;
      bus.frames_pending <= '0;
    end else begin
      full               <= full_nxt;
      bus.frames_pending <= {1'b0, full_nxt[0]} + {1'b0, full_nxt[1]};
      bus.len_err        <= wr_err;
      bus.frame_done     <= rd_last;
      bus.din_ready      <= w_next == W_RECV;
      if (wr_start) wr_idx <= '0;
      if (wr_acc) wr_idx <= wr_idx + IDX_W'(1);
      if (wr_last) wr_ptr <= ~wr_ptr;
      if (rd_arm) bus.user_recv_done <= 1'b1;
      if (rd_go) begin
        bus.user_recv_done <= 1'b0;
        rd_idx             <= rd_first;
        bus.data_out       <= mem[{rd_ptr, rd_first}];
        bus.shift_strobe   <= 1'b1;
      end
      if (rd_step && !rd_last) begin
        rd_idx       <= rd_nxt;
        bus.data_out <= mem[{rd_ptr, rd_nxt}];
      end
      if (rd_last) begin
        bus.shift_strobe <= 1'b0;
        rd_ptr           <= ~rd_ptr;
      end
    end
  end
endmodule

// File: tb/tb_ppm_frame_pingpong_buffer.sv
// tb_ppm_frame_pingpong_buffer: directed bench; u_rev sends last-to-first, u_fwd first-to-last
module tb_ppm_frame_pingpong_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  ppm_frame_pingpong_buffer_if #(.DATA_W(8), .LEN_W(5)) a ();
  ppm_frame_pingpong_buffer_if #(.DATA_W(8), .LEN_W(5)) f ();
  assign f.le          = a.le;
  assign f.n           = a.n;
  assign f.din         = a.din;
  assign f.din_valid   = a.din_valid;
  assign f.start_trans = a.start_trans;
  assign f.send_done   = a.send_done;
  ppm_frame_pingpong_buffer #(.DATA_W(8), .DEPTH(16), .LEN_W(5), .REVERSE(1'b1)) u_rev (
    .clk(clk), .rst(rst), .bus(a));
  ppm_frame_pingpong_buffer #(.DATA_W(8), .DEPTH(16), .LEN_W(5), .REVERSE(1'b0)) u_fwd (
    .clk(clk), .rst(rst), .bus(f));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a.le = 1'b0; a.n = '0; a.din = '0; a.din_valid = 1'b0;
    a.start_trans = 1'b0; a.send_done = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic load_seq(input int len, input logic [7:0] first);
    a.le = 1'b1; a.n = 5'(len);
    tick();
    a.le = 1'b0;
    for (int i = 0; i < len; i++) begin
      a.din = first + 8'(i); a.din_valid = 1'b1;
      tick();
    end
    a.din_valid = 1'b0;
  endtask

  task automatic start();
    a.start_trans = 1'b1;
    tick();
    a.start_trans = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({a.din_ready, a.data_out, a.shift_strobe, a.user_recv_done, a.frame_done, a.len_err, a.frames_pending} !== 15'd0) begin
      fails++; $display("FAIL reset_rev got %h want 0", {a.din_ready, a.data_out, a.shift_strobe, a.user_recv_done, a.frame_done, a.len_err, a.frames_pending});
    end
    tests++;
    if ({f.din_ready, f.data_out, f.shift_strobe, f.user_recv_done, f.frame_done, f.len_err, f.frames_pending} !== 15'd0) begin
      fails++; $display("FAIL reset_fwd got %h want 0", {f.din_ready, f.data_out, f.shift_strobe, f.user_recv_done, f.frame_done, f.len_err, f.frames_pending});
    end
  endtask

  task automatic test_basic_reverse();
    do_reset();
    load_seq(3, 8'hA1);
    tests++;
    if (a.frames_pending !== 2'd1) begin fails++; $display("FAIL basic_pending got %0d want 1", a.frames_pending); end
    tests++;
    if (a.din_ready !== 1'b0) begin fails++; $display("FAIL basic_ready_drop got %b want 0", a.din_ready); end
    tick();
    tests++;
    if (a.user_recv_done !== 1'b1) begin fails++; $display("FAIL basic_recv_done got %b want 1", a.user_recv_done); end
    start();
    tests++;
    if (a.data_out !== 8'hA3 || a.shift_strobe !== 1'b1) begin
      fails++; $display("FAIL basic_first got %h/%b want a3/1", a.data_out, a.shift_strobe);
    end
    tests++;
    if (a.user_recv_done !== 1'b0) begin fails++; $display("FAIL basic_recv_clear got %b want 0", a.user_recv_done); end
    a.send_done = 1'b1;
    tick();
    tests++;
    if (a.data_out !== 8'hA2) begin fails++; $display("FAIL basic_second got %h want a2", a.data_out); end
    tick();
    tests++;
    if (a.data_out !== 8'hA1 || a.frame_done !== 1'b0) begin
      fails++; $display("FAIL basic_third got %h/%b want a1/0", a.data_out, a.frame_done);
    end
    tick();
    a.send_done = 1'b0;
    tests++;
    if ({a.frame_done, a.shift_strobe, a.data_out, a.frames_pending} !== {1'b1, 1'b0, 8'hA1, 2'd0}) begin
      fails++; $display("FAIL basic_done got fd=%b ss=%b d=%h fp=%0d want 1 0 a1 0", a.frame_done, a.shift_strobe, a.data_out, a.frames_pending);
    end
    tick();
    tests++;
    if (a.frame_done !== 1'b0 || a.shift_strobe !== 1'b0) begin
      fails++; $display("FAIL basic_done_pulse got fd=%b ss=%b want 0 0", a.frame_done, a.shift_strobe);
    end
  endtask

  task automatic test_full_depth_forward();
    int bad;
    do_reset();
    load_seq(16, 8'h00);
    tick();
    tests++;
    if (f.user_recv_done !== 1'b1 || f.frames_pending !== 2'd1) begin
      fails++; $display("FAIL depth_loaded got urd=%b fp=%0d want 1 1", f.user_recv_done, f.frames_pending);
    end
    start();
    bad = 0;
    a.send_done = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (f.data_out !== 8'(i) || f.shift_strobe !== 1'b1 || f.frame_done !== 1'b0) begin
        fails++; $display("FAIL depth_word%0d got %h/%b want %h/1", i, f.data_out, f.shift_strobe, 8'(i));
      end
      tick();
    end
    a.send_done = 1'b0;
    tests++;
    if ({f.frame_done, f.shift_strobe, f.data_out, f.frames_pending} !== {1'b1, 1'b0, 8'h0F, 2'd0}) begin
      fails++; $display("FAIL depth_done got fd=%b ss=%b d=%h fp=%0d want 1 0 0f 0", f.frame_done, f.shift_strobe, f.data_out, f.frames_pending);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    load_seq(2, 8'h10);
    tick();
    start();
    tests++;
    if (a.data_out !== 8'h11) begin fails++; $display("FAIL pp_a_first got %h want 11", a.data_out); end
    load_seq(4, 8'h20);
    tests++;
    if (a.frames_pending !== 2'd2) begin fails++; $display("FAIL pp_pending2 got %0d want 2", a.frames_pending); end
    tests++;
    if (a.user_recv_done !== 1'b0) begin fails++; $display("FAIL pp_urd_busy got %b want 0", a.user_recv_done); end
    a.le = 1'b1; a.n = 5'd3;
    tick();
    a.le = 1'b0;
    tick();
    tests++;
    if (a.din_ready !== 1'b0 || a.len_err !== 1'b0) begin
      fails++; $display("FAIL pp_third_le got rdy=%b err=%b want 0 0", a.din_ready, a.len_err);
    end
    start();
    a.send_done = 1'b1;
    tick();
    tests++;
    if (a.data_out !== 8'h10) begin fails++; $display("FAIL pp_a_second got %h want 10", a.data_out); end
    tick();
    a.send_done = 1'b0;
    tests++;
    if ({a.frame_done, a.frames_pending, a.user_recv_done} !== {1'b1, 2'd1, 1'b0}) begin
      fails++; $display("FAIL pp_a_done got fd=%b fp=%0d urd=%b want 1 1 0", a.frame_done, a.frames_pending, a.user_recv_done);
    end
    tick();
    tick();
    tests++;
    if (a.user_recv_done !== 1'b1 || a.shift_strobe !== 1'b0 || a.data_out !== 8'h10) begin
      fails++; $display("FAIL pp_b_wait got urd=%b ss=%b d=%h want 1 0 10", a.user_recv_done, a.shift_strobe, a.data_out);
    end
    start();
    tests++;
    if (a.data_out !== 8'h23 || a.shift_strobe !== 1'b1) begin
      fails++; $display("FAIL pp_b_first got %h/%b want 23/1", a.data_out, a.shift_strobe);
    end
    a.send_done = 1'b1;
    for (int i = 2; i >= 0; i--) begin
      tick();
      tests++;
      if (a.data_out !== 8'h20 + 8'(i)) begin fails++; $display("FAIL pp_b_word%0d got %h want %h", i, a.data_out, 8'h20 + 8'(i)); end
    end
    tick();
    a.send_done = 1'b0;
    tests++;
    if ({a.frame_done, a.frames_pending} !== {1'b1, 2'd0}) begin
      fails++; $display("FAIL pp_b_done got fd=%b fp=%0d want 1 0", a.frame_done, a.frames_pending);
    end
  endtask

  task automatic test_len_err();
    do_reset();
    a.le = 1'b1; a.n = 5'd0;
    tick();
    a.le = 1'b0;
    tests++;
    if (a.len_err !== 1'b1 || a.din_ready !== 1'b0) begin
      fails++; $display("FAIL lenerr_zero got err=%b rdy=%b want 1 0", a.len_err, a.din_ready);
    end
    tick();
    tests++;
    if (a.len_err !== 1'b0) begin fails++; $display("FAIL lenerr_pulse got %b want 0", a.len_err); end
    a.le = 1'b1; a.n = 5'd17;
    tick();
    a.le = 1'b0;
    tests++;
    if (a.len_err !== 1'b1 || a.din_ready !== 1'b0) begin
      fails++; $display("FAIL lenerr_17 got err=%b rdy=%b want 1 0", a.len_err, a.din_ready);
    end
    tick();
    tests++;
    if ({a.len_err, a.din_ready, a.frames_pending, a.user_recv_done} !== 5'd0) begin
      fails++; $display("FAIL lenerr_after got err=%b rdy=%b fp=%0d urd=%b want 0 0 0 0", a.len_err, a.din_ready, a.frames_pending, a.user_recv_done);
    end
  endtask

  task automatic test_valid_toggle();
    logic [7:0] vals [5] = '{8'h31, 8'hEE, 8'h32, 8'hEE, 8'h33};
    do_reset();
    a.le = 1'b1; a.n = 5'd3;
    tick();
    a.le = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a.din = vals[i]; a.din_valid = (i % 2 == 0);
      tick();
    end
    a.din_valid = 1'b0;
    tests++;
    if (a.frames_pending !== 2'd1 || a.din_ready !== 1'b0) begin
      fails++; $display("FAIL toggle_loaded got fp=%0d rdy=%b want 1 0", a.frames_pending, a.din_ready);
    end
    a.send_done = 1'b1;
    tick();
    tick();
    a.send_done = 1'b0;
    tests++;
    if ({a.shift_strobe, a.frame_done, a.user_recv_done, a.frames_pending} !== {1'b0, 1'b0, 1'b1, 2'd1}) begin
      fails++; $display("FAIL toggle_idle_send got ss=%b fd=%b urd=%b fp=%0d want 0 0 1 1", a.shift_strobe, a.frame_done, a.user_recv_done, a.frames_pending);
    end
    start();
    tests++;
    if (a.data_out !== 8'h33) begin fails++; $display("FAIL toggle_w0 got %h want 33", a.data_out); end
    a.send_done = 1'b1;
    tick();
    tests++;
    if (a.data_out !== 8'h32) begin fails++; $display("FAIL toggle_w1 got %h want 32", a.data_out); end
    tick();
    tests++;
    if (a.data_out !== 8'h31) begin fails++; $display("FAIL toggle_w2 got %h want 31", a.data_out); end
    tick();
    a.send_done = 1'b0;
    tests++;
    if (a.frame_done !== 1'b1) begin fails++; $display("FAIL toggle_done got %b want 1", a.frame_done); end
  endtask

  task automatic test_reset_mid_send();
    do_reset();
    load_seq(2, 8'h40);
    tick();
    start();
    load_seq(2, 8'h50);
    tests++;
    if (a.frames_pending !== 2'd2) begin fails++; $display("FAIL rstmid_pending got %0d want 2", a.frames_pending); end
    a.send_done = 1'b1;
    tick();
    a.send_done = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({a.din_ready, a.data_out, a.shift_strobe, a.user_recv_done, a.frame_done, a.len_err, a.frames_pending} !== 15'd0) begin
      fails++; $display("FAIL rstmid_outputs got %h want 0", {a.din_ready, a.data_out, a.shift_strobe, a.user_recv_done, a.frame_done, a.len_err, a.frames_pending});
    end
    start();
    tick();
    tests++;
    if (a.shift_strobe !== 1'b0 || a.user_recv_done !== 1'b0 || a.frames_pending !== 2'd0) begin
      fails++; $display("FAIL rstmid_stale_start got ss=%b urd=%b fp=%0d want 0 0 0", a.shift_strobe, a.user_recv_done, a.frames_pending);
    end
    load_seq(1, 8'h77);
    tick();
    tests++;
    if (a.user_recv_done !== 1'b1) begin fails++; $display("FAIL single_urd got %b want 1", a.user_recv_done); end
    start();
    tests++;
    if (a.data_out !== 8'h77 || a.shift_strobe !== 1'b1) begin
      fails++; $display("FAIL single_word got %h/%b want 77/1", a.data_out, a.shift_strobe);
    end
    a.send_done = 1'b1;
    tick();
    a.send_done = 1'b0;
    tests++;
    if ({a.frame_done, a.shift_strobe, a.frames_pending} !== {1'b1, 1'b0, 2'd0}) begin
      fails++; $display("FAIL single_done got fd=%b ss=%b fp=%0d want 1 0 0", a.frame_done, a.shift_strobe, a.frames_pending);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_reverse();
    test_full_depth_forward();
    test_back_to_back();
    test_len_err();
    test_valid_toggle();
    test_reset_mid_send();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
